// File: rtl/player_ctrl.sv
// player_ctrl: per-frame player motion, lives/invulnerability FSM and shot cooldown
module player_ctrl #(
  parameter int X_MIN         = 0,
  parameter int X_MAX         = 639,
  parameter int Y_MIN         = 0,
  parameter int Y_MAX         = 479,
  parameter int X_START       = 320,
  parameter int Y_START       = 440,
  parameter int SIZE          = 5,
  parameter int STEP          = 2,
  parameter int KEY_SLOTS     = 2,
  parameter int LIVES_INIT    = 3,
  parameter int LIVES_W       = 2,
  parameter int INVULN_FRAMES = 60,
  parameter int SHOT_COOLDOWN = 15
) (
  input  logic                   frame_clk,
  input  logic                   Reset_n,
  input  logic [8*KEY_SLOTS-1:0] keycode,
  input  logic                   collision,
  output logic [9:0]             PlayerX,
  output logic [9:0]             PlayerY,
  output logic [9:0]             PlayerS,
  output logic [LIVES_W-1:0]     lives,
  output logic                   invuln,
  output logic                   game_over,
  output logic                   player_shoot
);
  localparam logic [1:0] ALIVE  = 2'd0;
  localparam logic [1:0] INVULN = 2'd1;
  localparam logic [1:0] DEAD   = 2'd2;
  logic [1:0] state;
  logic [15:0] cd, invuln_cnt;
  logic k_l, k_r, k_u, k_d, k_f;
  logic signed [10:0] dx, dy, nx, ny;
  logic hit, dying, fire;
  function automatic logic [9:0] clamp(input logic signed [10:0] v, input int lo, input int hi);
    return v < $signed(11'(lo)) ? 10'(lo) : v > $signed(11'(hi)) ? 10'(hi) : v[9:0];
  endfunction
  always_comb begin
    k_l = 1'b0;
    k_r = 1'b0;
    k_u = 1'b0;
    k_d = 1'b0;
    k_f = 1'b0;
    for (int i = 0; i < KEY_SLOTS; i++) begin
      k_l |= keycode[8*i+:8] == 8'h04;
      k_r |= keycode[8*i+:8] == 8'h07;
      k_u |= keycode[8*i+:8] == 8'h1A;
      k_d |= keycode[8*i+:8] == 8'h16;
      k_f |= keycode[8*i+:8] == 8'h2C;
    end
    dx = (k_r && !k_l) ? 11'(STEP) : (k_l && !k_r) ? -11'(STEP) : 11'sd0;
    dy = (k_d && !k_u) ? 11'(STEP) : (k_u && !k_d) ? -11'(STEP) : 11'sd0;
    nx = $signed({1'b0, PlayerX}) + dx;
    ny = $signed({1'b0, PlayerY}) + dy;
    hit = state == ALIVE && collision;
    dying = hit && lives <= LIVES_W'(1);
    // the frame that enters DEAD must not fire
    fire = k_f && cd == 16'd0 && state != DEAD && !dying;
  end
  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      PlayerX      <= 10'(X_START);
      PlayerY      <= 10'(Y_START);
      lives        <= LIVES_W'(LIVES_INIT);
      state        <= ALIVE;
      cd           <= 16'd0;
      invuln_cnt   <= 16'd0;
      player_shoot <= 1'b0;
    end else begin
      if (state != DEAD) begin
        PlayerX <= clamp(nx, X_MIN + SIZE, X_MAX - SIZE);
        PlayerY <= clamp(ny, Y_MIN + SIZE, Y_MAX - SIZE);
      end
      player_shoot <= fire;
      cd <= fire ? 16'(SHOT_COOLDOWN) : cd == 16'd0 ? cd : cd - 16'd1;
      if (hit) begin
        lives      <= lives - LIVES_W'(1);
        state      <= dying ? DEAD : INVULN;
        invuln_cnt <= 16'(INVULN_FRAMES - 1);
      end else if (state == INVULN) begin
        state      <= invuln_cnt == 16'd0 ? ALIVE : INVULN;
        invuln_cnt <= invuln_cnt == 16'd0 ? invuln_cnt : invuln_cnt - 16'd1;
      end
    end
  end
  assign PlayerS   = 10'(SIZE);
  assign invuln    = state == INVULN;
  assign game_over = state == DEAD;
endmodule

// File: tb/tb_player_ctrl.sv
// tb_player_ctrl: directed vector table plus multi-frame sequences for player_ctrl
module tb_player_ctrl;
  logic frame_clk = 1'b0;
  logic Reset_n = 1'b0;
  logic [15:0] keycode = 16'h0000;
  logic collision = 1'b0;
  logic [9:0] PlayerX, PlayerY, PlayerS;
  logic [1:0] lives;
  logic invuln, game_over, player_shoot;
  int total = 0;
  int passed = 0;

  player_ctrl dut (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .keycode(keycode), .collision(collision),
    .PlayerX(PlayerX), .PlayerY(PlayerY), .PlayerS(PlayerS), .lives(lives),
    .invuln(invuln), .game_over(game_over), .player_shoot(player_shoot)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    logic [15:0] key;
    logic col, rn;
    logic [9:0] x, y;
    logic [1:0] l;
    logic i, g, s;
  } vec_t;
  vec_t v[11];

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0d exp=%0d", n, got, exp);
  endtask

  task automatic step(input logic [15:0] k, input logic c, input logic rn);
    @(negedge frame_clk);
    keycode = k;
    collision = c;
    Reset_n = rn;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic chk_reset(input string n);
    chk({n, "_x"}, PlayerX, 320);
    chk({n, "_y"}, PlayerY, 440);
    chk({n, "_lives"}, lives, 3);
    chk({n, "_inv"}, invuln, 0);
    chk({n, "_go"}, game_over, 0);
    chk({n, "_shoot"}, player_shoot, 0);
  endtask

  initial begin
    int e;
    logic [9:0] xs;
    v[0]  = '{16'h0000, 1'b0, 1'b0, 10'd320, 10'd440, 2'd3, 1'b0, 1'b0, 1'b0};
    v[1]  = '{16'h0000, 1'b0, 1'b1, 10'd320, 10'd440, 2'd3, 1'b0, 1'b0, 1'b0};
    v[2]  = '{16'h0004, 1'b0, 1'b1, 10'd318, 10'd440, 2'd3, 1'b0, 1'b0, 1'b0};
    v[3]  = '{16'h0007, 1'b0, 1'b1, 10'd320, 10'd440, 2'd3, 1'b0, 1'b0, 1'b0};
    v[4]  = '{16'h0704, 1'b0, 1'b1, 10'd320, 10'd440, 2'd3, 1'b0, 1'b0, 1'b0};
    v[5]  = '{16'h1A07, 1'b0, 1'b1, 10'd322, 10'd438, 2'd3, 1'b0, 1'b0, 1'b0};
    v[6]  = '{16'h2C00, 1'b0, 1'b1, 10'd322, 10'd438, 2'd3, 1'b0, 1'b0, 1'b1};
    v[7]  = '{16'h2C00, 1'b0, 1'b1, 10'd322, 10'd438, 2'd3, 1'b0, 1'b0, 1'b0};
    v[8]  = '{16'h0016, 1'b1, 1'b1, 10'd322, 10'd440, 2'd2, 1'b1, 1'b0, 1'b0};
    v[9]  = '{16'h0000, 1'b1, 1'b1, 10'd322, 10'd440, 2'd2, 1'b1, 1'b0, 1'b0};
    v[10] = '{16'h0004, 1'b0, 1'b1, 10'd320, 10'd440, 2'd2, 1'b1, 1'b0, 1'b0};
    for (int r = 0; r < 11; r++) begin
      step(v[r].key, v[r].col, v[r].rn);
      chk($sformatf("vec%0d_x", r), PlayerX, v[r].x);
      chk($sformatf("vec%0d_y", r), PlayerY, v[r].y);
      chk($sformatf("vec%0d_lives", r), lives, v[r].l);
      chk($sformatf("vec%0d_inv", r), invuln, v[r].i);
      chk($sformatf("vec%0d_go", r), game_over, v[r].g);
      chk($sformatf("vec%0d_shoot", r), player_shoot, v[r].s);
    end
    chk("size", PlayerS, 5);
    // hit taken at vec8: invuln spans exactly 60 frames, then a hit counts again
    for (int k = 0; k < 57; k++) begin
      step(16'h0000, 1'b1, 1'b1);
      chk($sformatf("inv_hold%0d", k), invuln, 1);
    end
    chk("inv_hold_lives", lives, 2);
    step(16'h0000, 1'b0, 1'b1);
    chk("inv_end", invuln, 0);
    chk("inv_end_lives", lives, 2);
    step(16'h0000, 1'b1, 1'b1);
    chk("hit61_lives", lives, 1);
    chk("hit61_inv", invuln, 1);
    // reset mid-invuln, then idle
    step(16'h0000, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) step(16'h0000, 1'b0, 1'b1);
    chk_reset("idle");
    // left clamp then right clamp
    for (int k = 1; k <= 200; k++) begin
      step(16'h0004, 1'b0, 1'b1);
      e = 320 - 2 * k;
      if (e < 5) e = 5;
      chk($sformatf("left%0d", k), PlayerX, e);
    end
    for (int k = 1; k <= 330; k++) begin
      step(16'h0007, 1'b0, 1'b1);
      e = 5 + 2 * k;
      if (e > 634) e = 634;
      chk($sformatf("right%0d", k), PlayerX, e);
    end
    // three separated hits -> DEAD
    step(16'h0000, 1'b0, 1'b0);
    step(16'h002C, 1'b1, 1'b1);
    chk("h1_lives", lives, 2);
    chk("h1_shoot", player_shoot, 1);
    for (int k = 0; k < 60; k++) step(16'h0000, 1'b0, 1'b1);
    chk("h1_inv_done", invuln, 0);
    step(16'h0000, 1'b1, 1'b1);
    chk("h2_lives", lives, 1);
    for (int k = 0; k < 60; k++) step(16'h0000, 1'b0, 1'b1);
    step(16'h002C, 1'b1, 1'b1);
    chk("h3_lives", lives, 0);
    chk("h3_go", game_over, 1);
    chk("h3_inv", invuln, 0);
    chk("h3_shoot", player_shoot, 0);
    xs = PlayerX;
    for (int k = 0; k < 5; k++) begin
      step(16'h2C07, 1'b1, 1'b1);
      chk($sformatf("dead%0d_x", k), PlayerX, xs);
      chk($sformatf("dead%0d_shoot", k), player_shoot, 0);
      chk($sformatf("dead%0d_go", k), game_over, 1);
    end
    chk("dead_x_orig", xs, 320);
    step(16'h0000, 1'b0, 1'b0);
    chk_reset("dead_rst");
    // fire cadence, then reset mid-cooldown
    for (int k = 0; k < 40; k++) begin
      step(16'h002C, 1'b0, 1'b1);
      chk($sformatf("fire%0d", k), player_shoot, (k % 16) == 0);
    end
    step(16'h002C, 1'b0, 1'b0);
    chk("fire_rst", player_shoot, 0);
    step(16'h002C, 1'b0, 1'b1);
    chk("fire_after_rst", player_shoot, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
